// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - instruction memory with handshaked fetch port and FIFO_DEPTH-entry output buffer
// Optional word parity is built when IMEM_PARITY_EN is defined.
module instr_fetch_mem #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic                  load_perr_inject,
  output logic                  inst_perr,
`endif
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  input  logic                  flush,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_addr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int MEM_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;

  // Skid storage behind the output register; it only ever holds FIFO_DEPTH-1 entries.
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           fcnt_q, fcnt_d;
  logic [PW:0]           count;

  logic accept, consume, push, pop;

`ifdef IMEM_PARITY_EN
  logic mem_par_q [MEM_WORDS];
  logic fifo_perr_q [FIFO_DEPTH];
  logic out_perr_q, out_perr_d;
  logic rd_perr;
`endif

  assign rd_data     = mem_q[fetch_addr];
  assign count       = fcnt_q + (PW + 1)'(out_valid_q);
  assign fetch_ready = !rst && (count < DEPTH_C);
  assign accept      = fetch_req && fetch_ready && !flush;
  assign consume     = out_valid_q && inst_ready && !flush;

  assign inst_valid = out_valid_q;
  assign inst_data  = out_data_q;
  assign inst_addr  = out_addr_q;

  // Read-first: the array read sees the word before this edge's load lands.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

`ifdef IMEM_PARITY_EN
  assign rd_perr   = (^rd_data) ^ mem_par_q[fetch_addr];
  assign inst_perr = out_perr_q;

  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_par_q[load_addr] <= (^load_data) ^ load_perr_inject;
    end
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fcnt_d      = fcnt_q;
    push        = 1'b0;
    pop         = 1'b0;
`ifdef IMEM_PARITY_EN
    out_perr_d  = out_perr_q;
`endif
    if (flush) begin
      out_valid_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fcnt_d      = '0;
    end else begin
      if (!out_valid_q || consume) begin
        if (fcnt_q != '0) begin
          out_valid_d = 1'b1;
          out_data_d  = fifo_data_q[rd_ptr_q];
          out_addr_d  = fifo_addr_q[rd_ptr_q];
`ifdef IMEM_PARITY_EN
          out_perr_d  = fifo_perr_q[rd_ptr_q];
`endif
          pop  = 1'b1;
          push = accept;
        end else if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_data;
          out_addr_d  = fetch_addr;
`ifdef IMEM_PARITY_EN
          out_perr_d  = rd_perr;
`endif
        end else begin
          out_valid_d = 1'b0;
        end
      end else begin
        push = accept;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        fcnt_d = fcnt_q + (PW + 1)'(1);
      end else if (pop && !push) begin
        fcnt_d = fcnt_q - (PW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
`ifdef IMEM_PARITY_EN
      out_perr_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
`ifdef IMEM_PARITY_EN
      out_perr_q  <= out_perr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rd_data;
      fifo_addr_q[wr_ptr_q] <= fetch_addr;
`ifdef IMEM_PARITY_EN
      fifo_perr_q[wr_ptr_q] <= rd_perr;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - scoreboard bench for instr_fetch_mem
// Define IMEM_PARITY_EN to also exercise the parity port.
module tb_instr_fetch_mem;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          perr;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_perr_inject;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          flush;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_addr;
  logic          inst_perr_w;

  int total = 0;
  int bad = 0;

  ent_t          sb[$];
  logic [DW-1:0] mem_m [2**AW];
  logic          par_m [2**AW];

  logic          popped;
  logic [DW-1:0] pop_d;
  logic [AW-1:0] pop_a;
  logic          pop_p;

  instr_fetch_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .load_we(load_we),
    .load_addr(load_addr),
    .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .load_perr_inject(load_perr_inject),
    .inst_perr(inst_perr_w),
`endif
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready),
    .flush(flush),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_addr(inst_addr)
  );

`ifndef IMEM_PARITY_EN
  assign inst_perr_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: compare outputs against the model, then advance model across the edge.
  task automatic tick();
    logic exp_v, exp_rdy, acc, con;
    ent_t e;
    #1;
    exp_v   = (sb.size() > 0);
    exp_rdy = !rst && (sb.size() < DEPTH);
    total++;
    if (inst_valid !== exp_v) begin
      bad++;
      $display("FAIL inst_valid t=%0t got=%b exp=%b", $time, inst_valid, exp_v);
    end
    total++;
    if (fetch_ready !== exp_rdy) begin
      bad++;
      $display("FAIL fetch_ready t=%0t got=%b exp=%b", $time, fetch_ready, exp_rdy);
    end
    if (exp_v) begin
      total++;
      if (inst_data !== sb[0].data || inst_addr !== sb[0].addr) begin
        bad++;
        $display("FAIL head t=%0t got=%h@%h exp=%h@%h", $time, inst_data, inst_addr,
                 sb[0].data, sb[0].addr);
      end
`ifdef IMEM_PARITY_EN
      total++;
      if (inst_perr_w !== sb[0].perr) begin
        bad++;
        $display("FAIL head_perr t=%0t got=%b exp=%b", $time, inst_perr_w, sb[0].perr);
      end
`endif
    end
    acc    = fetch_req && exp_rdy && !flush;
    con    = exp_v && inst_ready && !flush;
    popped = con;
    if (con) begin
      pop_d = inst_data;
      pop_a = inst_addr;
      pop_p = inst_perr_w;
    end
    @(posedge clk);
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (con) void'(sb.pop_front());
      if (acc) begin
        e.data = mem_m[fetch_addr];
        e.addr = fetch_addr;
        e.perr = (^mem_m[fetch_addr]) ^ par_m[fetch_addr];
        sb.push_back(e);
      end
    end
    if (load_we) begin
      mem_m[load_addr] = load_data;
      par_m[load_addr] = (^load_data) ^ load_perr_inject;
    end
    #1;
  endtask

  task automatic idle_inputs();
    load_we = 1'b0;
    load_perr_inject = 1'b0;
    fetch_req = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    load_addr = '0;
    load_data = '0;
    fetch_addr = '0;
    inst_ready = 1'b0;
    @(posedge clk);
    #1;
    tick();
    total++;
    if (inst_data !== 16'h0 || inst_addr !== 6'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h@%h exp=0000@00", inst_data, inst_addr);
    end
    rst = 1'b0;
    #1;
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b exp=1", fetch_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      load_we = 1'b1;
      load_addr = AW'(i);
      load_data = 16'h1001 + DW'(i);
      tick();
    end
    load_we = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch_req = (i < 4);
      fetch_addr = AW'(i);
      tick();
      if (i > 0) begin
        total++;
        if (!popped || pop_d !== 16'h1001 + DW'(i - 1) || pop_a !== AW'(i - 1)) begin
          bad++;
          $display("FAIL b2b_word%0d got=%b:%h@%h exp=1:%h@%h", i - 1, popped, pop_d, pop_a,
                   16'h1001 + DW'(i - 1), AW'(i - 1));
        end
      end
    end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    inst_ready = 1'b0;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = AW'(i);
      tick();
      if (i == 1) begin
        total++;
        if (fetch_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_full_ready got=%b exp=0", fetch_ready);
        end
      end
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) fetch_req = 1'b0;
      tick();
      total++;
      if (!popped || pop_a !== AW'(i) || pop_d !== 16'h1001 + DW'(i)) begin
        bad++;
        $display("FAIL stall_order%0d got=%b:%h@%h exp=1:%h@%h", i, popped, pop_d, pop_a,
                 16'h1001 + DW'(i), AW'(i));
      end
    end
    tick();
  endtask

  task automatic test_flush();
    inst_ready = 1'b0;
    fetch_req = 1'b1;
    fetch_addr = 6'd0;
    tick();
    fetch_addr = 6'd1;
    tick();
    flush = 1'b1;
    fetch_addr = 6'd5;
    tick();
    total++;
    if (inst_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_clear got=valid%b ready%b exp=valid0 ready1", inst_valid, fetch_ready);
    end
    flush = 1'b0;
    fetch_req = 1'b0;
    tick();
    fetch_req = 1'b1;
    fetch_addr = 6'd3;
    inst_ready = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    total++;
    if (!popped || pop_d !== 16'h1004 || pop_a !== 6'd3) begin
      bad++;
      $display("FAIL flush_refetch got=%b:%h@%h exp=1:1004@03", popped, pop_d, pop_a);
    end
  endtask

  task automatic test_collision();
    inst_ready = 1'b1;
    load_we = 1'b1;
    load_addr = 6'd2;
    load_data = 16'hBEEF;
    fetch_req = 1'b1;
    fetch_addr = 6'd2;
    tick();
    load_we = 1'b0;
    tick();
    total++;
    if (!popped || pop_d !== 16'h1003) begin
      bad++;
      $display("FAIL collision_old got=%b:%h exp=1:1003", popped, pop_d);
    end
    fetch_req = 1'b0;
    tick();
    total++;
    if (!popped || pop_d !== 16'hBEEF) begin
      bad++;
      $display("FAIL collision_new got=%b:%h exp=1:beef", popped, pop_d);
    end
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    fetch_req = 1'b1;
    fetch_addr = 6'd0;
    tick();
    fetch_addr = 6'd1;
    tick();
    fetch_req = 1'b0;
    rst = 1'b1;
    tick();
    total++;
    if (inst_valid !== 1'b0 || inst_data !== 16'h0 || fetch_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset got=v%b d%h r%b exp=v0 d0000 r0", inst_valid, inst_data, fetch_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_ready got=%b exp=1", fetch_ready);
    end
    inst_ready = 1'b1;
    fetch_req = 1'b1;
    fetch_addr = 6'd2;
    tick();
    fetch_req = 1'b0;
    tick();
    total++;
    if (!popped || pop_d !== 16'hBEEF) begin
      bad++;
      $display("FAIL midreset_mem got=%b:%h exp=1:beef", popped, pop_d);
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    load_we = 1'b1;
    load_addr = 6'd7;
    load_data = 16'h00FF;
    load_perr_inject = 1'b1;
    tick();
    load_addr = 6'd8;
    load_perr_inject = 1'b0;
    tick();
    load_we = 1'b0;
    inst_ready = 1'b1;
    fetch_req = 1'b1;
    fetch_addr = 6'd7;
    tick();
    fetch_addr = 6'd8;
    tick();
    total++;
    if (!popped || pop_p !== 1'b1 || pop_d !== 16'h00FF) begin
      bad++;
      $display("FAIL parity_bad got=%b:%h p%b exp=1:00ff p1", popped, pop_d, pop_p);
    end
    fetch_req = 1'b0;
    tick();
    total++;
    if (!popped || pop_p !== 1'b0 || pop_d !== 16'h00FF) begin
      bad++;
      $display("FAIL parity_good got=%b:%h p%b exp=1:00ff p0", popped, pop_d, pop_p);
    end
  endtask
`endif

  task automatic test_random();
    idle_inputs();
    inst_ready = 1'b0;
    for (int i = 0; i < 2**AW; i++) begin
      load_we = 1'b1;
      load_addr = AW'(i);
      load_data = DW'($urandom);
      tick();
    end
    for (int i = 0; i < 400; i++) begin
      load_we = ($urandom_range(0, 3) == 0);
      load_addr = AW'($urandom);
      load_data = DW'($urandom);
      fetch_req = ($urandom_range(0, 3) != 0);
      fetch_addr = AW'($urandom);
      inst_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle_inputs();
    rst = 1'b0;
    inst_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_collision();
    test_reset_mid();
`ifdef IMEM_PARITY_EN
    idle_inputs();
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised instruction memory with a decoupled fetch port. It replaces the bare always-read instruction RAM between the PC/fetch stage and the decoder. Program words are bootstrapped through a load port. Fetches use a request/ready handshake, and results return through a FIFO_DEPTH-entry output buffer with valid/ready back-pressure and a flush. The decoder can stall, and the PC can redirect on branches, without losing or duplicating instructions.

## Interface
- ADDR_WIDTH, 6, word-address width; memory holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, instruction word width.
- FIFO_DEPTH, 2, output buffer entries; power of two, >= 2.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- load_we  in  1  write load_data to load_addr at this edge.
- load_addr  in  ADDR_WIDTH  load address.
- load_data  in  DATA_WIDTH  load data.
- fetch_req  in  1  fetch request valid.
- fetch_addr  in  ADDR_WIDTH  word address to fetch.
- fetch_ready  out  1  block accepts a request this cycle.
- flush  in  1  discard all buffered and in-flight fetches.
- inst_valid  out  1  inst_data/inst_addr hold a valid fetched word.
- inst_ready  in  1  consumer takes the head entry this cycle.
- inst_data  out  DATA_WIDTH  fetched instruction.
- inst_addr  out  ADDR_WIDTH  address it was fetched from.

## Operation
- Accept: fetch_req && fetch_ready && !flush. Consume: inst_valid && inst_ready && !flush.
- count = accepted entries not yet consumed or flushed, including any read in flight.
- fetch_ready = !rst && (count < FIFO_DEPTH). It has no combinational dependence on inst_ready or fetch_req.
- Entries are returned strictly in acceptance order.
- Memory is synchronous single-read, single-write. A load and a fetch may both occur in the same cycle.
- Same-address collision is read-first: the fetch returns the pre-write word, and the new word is visible to fetches accepted from the next cycle onward.
- Memory contents are not reset and are not cleared by flush.
- flush clears count to 0 at the next edge. The head entry presented in the flush cycle is not consumed. A request presented during flush is not accepted.
- Accept and consume in the same cycle leave count unchanged.
- inst_data and inst_addr are registered and hold their value while inst_valid is low or the entry is stalled.
- Reset values: inst_valid 0, inst_data 0, inst_addr 0, count 0. fetch_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- Reset asserted mid-operation discards all entries and in-flight reads. Loads in a reset cycle are still written.
- Out-of-range addresses cannot occur: addresses are ADDR_WIDTH wide and wrap naturally.

## Timing
- Latency: a request accepted at edge N is presented with inst_valid=1 in the cycle after edge N, provided all older entries have been consumed.
- Throughput: one fetch per cycle sustained when inst_ready stays high (FIFO_DEPTH >= 2).
- Under stall, at most FIFO_DEPTH entries are held. fetch_ready drops in the cycle count reaches FIFO_DEPTH. It rises the cycle after the consume that frees a slot.
- Load write takes effect at the edge where load_we is sampled high.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores one extra even-parity bit computed from load_data.
  - Adds input load_perr_inject (1 bit), which stores the inverted parity bit when high with load_we.
  - Adds output inst_perr (1 bit, reset 0). It is valid with inst_valid and set when the stored parity mismatches the read data.
  - Data is still delivered unchanged.
- IMEM_PARITY_EN undefined: no parity storage, no load_perr_inject or inst_perr ports; behaviour is otherwise identical.

## Test plan
- Load addr 0..3 with 16'h1001..16'h1004, then fetch 0,1,2,3 on back-to-back cycles with inst_ready=1 -> inst_valid high for 4 consecutive cycles starting one cycle after the first accept; data 1001..1004 in order; inst_addr 0..3.
- Hold inst_ready=0 and request 0,1,2 -> only 2 accepted and fetch_ready=0 after the second. Raise inst_ready -> words for addr 0 then 1, then addr 2 is accepted; no loss or duplication.
- Two entries buffered, assert flush for one cycle with fetch_req on addr 5 -> next cycle inst_valid=0, count 0, addr 5 not accepted. Re-request addr 3 -> returns 16'h1004 after one cycle.
- Same cycle: load_we to addr 2 with 16'hBEEF, and fetch addr 2 -> returns 16'h1003. Fetch addr 2 next cycle -> returns 16'hBEEF.
- With 2 entries buffered, assert rst for one cycle -> inst_valid=0, inst_data=0, fetch_ready=0 during reset and 1 after. Memory still returns 16'hBEEF at addr 2.
- IMEM_PARITY_EN: load addr 7 = 16'h00FF with load_perr_inject=1, and addr 8 = 16'h00FF normally. Fetch 7 then 8 -> inst_perr 1 then 0, inst_data 16'h00FF both times.
